// File: rtl/regfile_scan_reader.sv
// regfile_scan_reader: streams a wrap-around range of register-file entries as (addr, data) pairs
//
// Ports:
//   i_clk          clock
//   i_reset        synchronous, active-high reset
//   i_start_val    scan request valid
//   o_start_rdy    scan request ready (IDLE and not in reset)
//   i_start_first  first register address of the scan
//   i_start_last   last register address of the scan (inclusive)
//   o_rd_addr      address to the register-file read port
//   i_rd_data      combinational data from the register-file read port
//   o_out_val      output entry valid
//   i_out_rdy      output entry ready
//   o_out_addr     register address of the entry
//   o_out_data     register value of the entry
//   o_out_last     entry is the final one of the scan
//   o_busy         scan in progress
module regfile_scan_reader #(
    parameter int DTYPE = 8,
    parameter int NREGS = 4,
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start_val,
    output logic             o_start_rdy,
    input  logic [AW-1:0]    i_start_first,
    input  logic [AW-1:0]    i_start_last,
    output logic [AW-1:0]    o_rd_addr,
    input  logic [DTYPE-1:0] i_rd_data,
    output logic             o_out_val,
    input  logic             i_out_rdy,
    output logic [AW-1:0]    o_out_addr,
    output logic [DTYPE-1:0] o_out_data,
    output logic             o_out_last,
    output logic             o_busy
);
    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    localparam logic [AW-1:0] MAXA = AW'(NREGS - 1);
    localparam logic [AW:0]   NRW  = (AW + 1)'(NREGS);

    state_t           r_state;
    logic [AW-1:0]    r_cur;
    logic [AW-1:0]    r_last;
    logic             r_out_val;
    logic [AW-1:0]    r_out_addr;
    logic [DTYPE-1:0] r_out_data;
    logic             r_out_last;

    logic          w_deq;
    logic          w_cap;
    logic          w_oor;
    logic [AW-1:0] w_next;

    // One-entry buffer refills in the same cycle it drains, giving 1 entry/cycle.
    assign w_deq  = r_out_val & i_out_rdy;
    assign w_cap  = ~r_out_val | i_out_rdy;
    // Only reachable when NREGS is not a power of two.
    assign w_oor  = ({1'b0, r_cur} >= NRW) || ({1'b0, r_last} >= NRW);
    assign w_next = (r_cur == MAXA) ? '0 : r_cur + 1'b1;

    assign o_start_rdy = (r_state == IDLE) & ~i_reset;
    assign o_rd_addr   = (r_state == SCAN) ? r_cur : '0;
    assign o_busy      = (r_state != IDLE);
    assign o_out_val   = r_out_val;
    assign o_out_addr  = r_out_addr;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_cur      <= '0;
            r_last     <= '0;
            r_out_val  <= 1'b0;
            r_out_addr <= '0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start_val) begin
                        r_cur   <= i_start_first;
                        r_last  <= i_start_last;
                        r_state <= SCAN;
                    end
                end
                SCAN: begin
                    if (w_oor) begin
                        r_state <= IDLE;
                    end else if (w_cap) begin
                        r_out_val  <= 1'b1;
                        r_out_addr <= r_cur;
                        r_out_data <= i_rd_data;
                        r_out_last <= (r_cur == r_last);
                        r_state    <= (r_cur == r_last) ? DRAIN : SCAN;
                        r_cur      <= (r_cur == r_last) ? r_cur : w_next;
                    end
                end
                DRAIN: begin
                    if (w_deq) begin
                        r_out_val <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_scan_reader.sv
// tb_regfile_scan_reader: directed self-checking bench for regfile_scan_reader
module tb_regfile_scan_reader;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_val = 1'b0;
    logic       start_rdy;
    logic [1:0] start_first = '0;
    logic [1:0] start_last = '0;
    logic [1:0] rd_addr;
    logic [7:0] rd_data;
    logic       out_val;
    logic       out_rdy = 1'b1;
    logic [1:0] out_addr;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    logic       we = 1'b0;
    logic [1:0] wa = '0;
    logic [7:0] wd = '0;
    logic [7:0] regs [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] exp_data [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    int n_tot = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // register file with write-through read bypass
    always @(posedge clk) if (we) regs[wa] <= wd;
    assign rd_data = (we && wa == rd_addr) ? wd : regs[rd_addr];

    regfile_scan_reader dut (
        .i_clk(clk), .i_reset(reset),
        .i_start_val(start_val), .o_start_rdy(start_rdy),
        .i_start_first(start_first), .i_start_last(start_last),
        .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_out_val(out_val), .i_out_rdy(out_rdy),
        .o_out_addr(out_addr), .o_out_data(out_data), .o_out_last(out_last),
        .o_busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic start(input logic [1:0] f, input logic [1:0] l);
        tick;
        check("start_rdy", start_rdy, 1);
        start_val = 1'b1;
        start_first = f;
        start_last = l;
        tick;
        start_val = 1'b0;
        check("lat_busy", busy, 1);
        check("lat_val", out_val, 0);
        check("lat_rd_addr", rd_addr, f);
    endtask

    task automatic expect_entry(input string tag, input logic [1:0] a, input logic [7:0] d, input logic l);
        check({tag, "_val"}, out_val, 1);
        check({tag, "_addr"}, out_addr, a);
        check({tag, "_data"}, out_data, d);
        check({tag, "_last"}, out_last, l);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_val"}, out_val, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rdy"}, start_rdy, 1);
    endtask

    task automatic scan(input string tag, input logic [1:0] f, input logic [1:0] l, input int n);
        logic [1:0] a;
        a = f;
        start(f, l);
        for (int i = 0; i < n; i++) begin
            tick;
            expect_entry(tag, a, exp_data[a], i == n - 1);
            a = (a == 2'd3) ? 2'd0 : a + 2'd1;
        end
        tick;
        expect_idle({tag, "_end"});
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [7:0] d);
        tick;
        we = 1'b1;
        wa = a;
        wd = d;
        tick;
        we = 1'b0;
    endtask

    initial begin
        tick;
        check("rst_start_rdy", start_rdy, 0);
        tick;
        check("rst_start_rdy2", start_rdy, 0);
        reset = 1'b0;
        tick;
        expect_idle("rst");
        check("rst_rd_addr", rd_addr, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);

        scan("full", 2'd0, 2'd3, 4);
        scan("wrap", 2'd3, 2'd1, 3);
        scan("single", 2'd2, 2'd2, 1);

        start(2'd0, 2'd3);
        tick;
        expect_entry("bp0", 2'd0, 8'h11, 0);
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            expect_entry("bp_hold", 2'd0, 8'h11, 0);
            check("bp_rd_addr", rd_addr, 1);
        end
        out_rdy = 1'b1;
        tick;
        expect_entry("bp1", 2'd1, 8'h22, 0);
        tick;
        expect_entry("bp2", 2'd2, 8'h33, 0);
        tick;
        expect_entry("bp3", 2'd3, 8'h44, 1);
        tick;
        expect_idle("bp_end");

        start(2'd2, 2'd2);
        check("byp_rd_addr", rd_addr, 2);
        we = 1'b1;
        wa = 2'd2;
        wd = 8'hAA;
        tick;
        we = 1'b0;
        expect_entry("byp", 2'd2, 8'hAA, 1);
        tick;
        expect_idle("byp_end");
        write_reg(2'd2, 8'h33);

        start(2'd0, 2'd0);
        tick;
        expect_entry("late0", 2'd0, 8'h11, 1);
        out_rdy = 1'b0;
        we = 1'b1;
        wa = 2'd0;
        wd = 8'h55;
        tick;
        we = 1'b0;
        expect_entry("late1", 2'd0, 8'h11, 1);
        out_rdy = 1'b1;
        tick;
        expect_idle("late_end");
        write_reg(2'd0, 8'h11);

        start(2'd0, 2'd3);
        tick;
        expect_entry("mr0", 2'd0, 8'h11, 0);
        tick;
        expect_entry("mr1", 2'd1, 8'h22, 0);
        tick;
        expect_entry("mr2", 2'd2, 8'h33, 0);
        reset = 1'b1;
        tick;
        check("mr_val", out_val, 0);
        check("mr_busy", busy, 0);
        check("mr_rdy_in_reset", start_rdy, 0);
        reset = 1'b0;
        tick;
        expect_idle("mr_after");
        scan("post", 2'd0, 2'd0, 1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
